// File: rtl/rr_bus_scheduler_pkg.sv
// Shared types and helpers for the round-robin bus scheduler:
// FSM state encoding and the {slave_id, master_id} bus_state word packing.
package bus_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        BUSY,
        PREEMPT,
        RELEASE
    } sched_state_t;

    localparam int ID_MAX_W = 16;
    localparam logic [ID_MAX_W-1:0] NO_SLAVE_ID = '0;

    // Ids are passed zero-extended to ID_MAX_W; callers cast the result to the real bus_state width.
    function automatic logic [2*ID_MAX_W-1:0] pack_bus_state(
        input logic [ID_MAX_W-1:0] slave_id,
        input logic [ID_MAX_W-1:0] master_id,
        input int                  m_w
    );
        logic [2*ID_MAX_W-1:0] s_ext;
        logic [2*ID_MAX_W-1:0] m_ext;
        s_ext = {{ID_MAX_W{1'b0}}, slave_id};
        m_ext = {{ID_MAX_W{1'b0}}, master_id};
        return (s_ext << m_w) | m_ext;
    endfunction

    function automatic logic [ID_MAX_W-1:0] bus_state_master(
        input logic [2*ID_MAX_W-1:0] bs,
        input int                    m_w
    );
        logic [2*ID_MAX_W-1:0] mask;
        mask = (2*ID_MAX_W)'((64'd1 << m_w) - 64'd1);
        return ID_MAX_W'(bs & mask);
    endfunction

    function automatic logic [ID_MAX_W-1:0] bus_state_slave(
        input logic [2*ID_MAX_W-1:0] bs,
        input int                    m_w
    );
        return ID_MAX_W'(bs >> m_w);
    endfunction

endpackage

// File: rtl/rr_bus_scheduler_if.sv
// Request/grant bundle between the per-master port decoders, the scheduler and the bus muxes.
// The scheduler uses the slave modport; the requesting side uses master.
interface rr_bus_scheduler_if #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
);

    logic [0:NO_MASTERS-1]              req;
    logic [S_ID_WIDTH-1:0]              req_slave [0:NO_MASTERS-1];
    logic [0:NO_MASTERS-1]              done;
    logic                               ready;
    logic [0:NO_MASTERS-1]              grant;
    logic [0:NO_MASTERS-1]              preempt;
    logic [S_ID_WIDTH+M_ID_WIDTH-1:0]   bus_state;
    logic                               busy;

    modport slave (
        input  req, req_slave, done, ready,
        output grant, preempt, bus_state, busy
    );

    modport master (
        output req, req_slave, done, ready,
        input  grant, preempt, bus_state, busy
    );

endinterface

// File: rtl/rr_bus_scheduler_picker.sv
// Round-robin search: first set bit of valid at or after ptr, wrapping modulo NO_MASTERS.
module rr_picker
    import bus_sched_pkg::*;
#(
    parameter int NO_MASTERS = 2,
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
    input  logic [0:NO_MASTERS-1]   valid,
    input  logic [M_ID_WIDTH-1:0]   ptr,
    output logic [M_ID_WIDTH-1:0]   idx,
    output logic                    found
);

    logic [M_ID_WIDTH-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NO_MASTERS; i++) begin
            cand = M_ID_WIDTH'((int'(ptr) + i) % NO_MASTERS);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_bus_scheduler.sv
// Round-robin bus-ownership scheduler: grants one master at a time, latches its target
// slave, and raises preempt after THRESH contended cycles of ownership.
module rr_bus_scheduler
    import bus_sched_pkg::*;
#(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int THRESH     = 10000000,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
    input  logic              clk,
    input  logic              rstN,
    rr_bus_scheduler_if.slave bus
);

    localparam int BS_W    = S_ID_WIDTH + M_ID_WIDTH;
    localparam int TIMER_W = $clog2(THRESH + 1);
    localparam logic [TIMER_W-1:0]    TIMER_MAX  = TIMER_W'(THRESH);
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(THRESH - 1);
    localparam logic [M_ID_WIDTH-1:0] LAST_M     = M_ID_WIDTH'(NO_MASTERS - 1);
    localparam logic [S_ID_WIDTH-1:0] MAX_SLAVE  = S_ID_WIDTH'(NO_SLAVES);

    sched_state_t          state_q, state_d;
    logic [M_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [M_ID_WIDTH-1:0] owner_q, owner_d;
    logic [S_ID_WIDTH-1:0] slave_q, slave_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;

    logic [0:NO_MASTERS-1] grant_q, grant_d;
    logic [0:NO_MASTERS-1] preempt_q, preempt_d;
    logic [BS_W-1:0]       bus_state_q, bus_state_d;
    logic                  busy_q, busy_d;

    logic [0:NO_MASTERS-1] valid_req;
    logic [0:NO_MASTERS-1] others;
    logic                  contended;
    logic                  owner_done;
    logic [M_ID_WIDTH-1:0] pick_idx;
    logic                  pick_found;

    always_comb begin
        valid_req = '0;
        for (int m = 0; m < NO_MASTERS; m++) begin
            valid_req[m] = bus.req[m]
                        && (bus.req_slave[m] != S_ID_WIDTH'(NO_SLAVE_ID))
                        && (bus.req_slave[m] <= MAX_SLAVE);
        end
    end

    // The owner's own request never counts as contention.
    always_comb begin
        others          = valid_req;
        others[owner_q] = 1'b0;
    end

    assign contended  = |others;
    assign owner_done = bus.done[owner_q] || !bus.req[owner_q];

    rr_picker #(
        .NO_MASTERS (NO_MASTERS),
        .M_ID_WIDTH (M_ID_WIDTH)
    ) u_picker (
        .valid (valid_req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        slave_d     = slave_q;
        timer_d     = timer_q;
        grant_d     = '0;
        preempt_d   = '0;
        bus_state_d = '0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pick_found) begin
                    owner_d = pick_idx;
                    slave_d = bus.req_slave[pick_idx];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (owner_done)     state_d = RELEASE;
                else if (bus.ready) state_d = BUSY;
            end
            BUSY: begin
                // A finishing owner beats a same-cycle timeout.
                if (owner_done)                  state_d = RELEASE;
                else if (timer_q == TIMER_LAST)  state_d = PREEMPT;
                else if (contended && timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
            end
            PREEMPT: begin
                if (owner_done) state_d = RELEASE;
            end
            RELEASE: begin
                timer_d = '0;
                ptr_d   = (owner_q == LAST_M) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        if (state_d == GRANT || state_d == BUSY || state_d == PREEMPT) begin
            grant_d[owner_d] = 1'b1;
            busy_d           = 1'b1;
            bus_state_d      = BS_W'(pack_bus_state(16'(slave_d), 16'(owner_d), M_ID_WIDTH));
        end
        if (state_d == PREEMPT) preempt_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            preempt_q   <= '0;
            bus_state_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            preempt_q   <= preempt_d;
            bus_state_q <= bus_state_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        owner_q <= owner_d;
        slave_q <= slave_d;
    end

    assign bus.grant     = grant_q;
    assign bus.preempt   = preempt_q;
    assign bus.bus_state = bus_state_q;
    assign bus.busy      = busy_q;

endmodule
